keypad_reader: RTL and testbench

KEYPAD_READER -- requirements
Module: keypad_reader

---
 rtl/keypad_reader_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_reader.sv | 136 +++++++++++++
 tb/tb_keypad_reader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_reader_pkg.sv
// Shared types, defaults and helpers for the 4x4 matrix keypad reader.
package keypad_reader_pkg;

    localparam int unsigned SCAN_DIV_DEF     = 50000;
    localparam int unsigned DEBOUNCE_CNT_DEF = 200000;
    localparam int unsigned ROW_W            = 4;
    localparam int unsigned COL_W            = 4;
    localparam int unsigned CODE_W           = 4;
    localparam int unsigned VALUE_W          = 16;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    // Key code is row index in the upper bits, column index in the lower bits.
    function automatic logic [CODE_W-1:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Lowest-index active-low row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low(input logic [ROW_W-1:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    function automatic logic [COL_W-1:0] col_drive(input logic [1:0] col);
        return 4'hF ^ (4'b0001 << col);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_reader.sv
// Column-scanning 4x4 keypad reader with press/release debounce and a
// four-digit hex entry buffer.
module keypad_reader
    import keypad_reader_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ROW_W-1:0]   row_in,
    input  logic               clear,
    output logic [COL_W-1:0]   col_out,
    output logic               key_valid,
    output logic [CODE_W-1:0]  key_code,
    output logic [VALUE_W-1:0] value_out,
    output logic               key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    logic [ROW_W-1:0]   rs;
    state_t             state, state_nxt;
    logic [1:0]         col_idx, col_nxt;
    logic [1:0]         row_sel, row_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [DEB_W-1:0]   deb_cnt, deb_nxt;
    logic [CODE_W-1:0]  code_nxt;
    logic [VALUE_W-1:0] value_nxt;
    logic               valid_nxt;

    sync_2ff #(
        .WIDTH     (ROW_W),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (rs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            col_idx   <= '0;
            row_sel   <= '0;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            col_out   <= 4'b1110;
            key_code  <= '0;
            value_out <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_nxt;
            row_sel   <= row_nxt;
            div_cnt   <= div_nxt;
            deb_cnt   <= deb_nxt;
            col_out   <= col_drive(col_nxt);
            key_code  <= code_nxt;
            value_out <= value_nxt;
            key_valid <= valid_nxt;
            key_held  <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE);
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        row_nxt   = row_sel;
        div_nxt   = div_cnt;
        deb_nxt   = deb_cnt;
        code_nxt  = key_code;
        value_nxt = value_out;
        valid_nxt = 1'b0;

        case (state)
            ST_SCAN: begin
                if (rs != 4'hF) begin
                    row_nxt   = lowest_low(rs);
                    deb_nxt   = '0;
                    state_nxt = ST_DEBOUNCE;
                end else if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    col_nxt = col_idx + 2'd1;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (rs[row_sel]) begin
                    div_nxt   = '0;
                    state_nxt = ST_SCAN;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = ST_HELD;
                    // A coincident clear suppresses the whole acceptance, not just the buffer.
                    if (!clear) begin
                        code_nxt  = key_code_of(row_sel, col_idx);
                        value_nxt = {value_out[VALUE_W-CODE_W-1:0], key_code_of(row_sel, col_idx)};
                        valid_nxt = 1'b1;
                    end
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end
            ST_HELD: begin
                if (rs == 4'hF) begin
                    deb_nxt   = '0;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rs != 4'hF) begin
                    deb_nxt   = '0;
                    state_nxt = ST_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    div_nxt   = '0;
                    col_nxt   = col_idx + 2'd1;
                    state_nxt = ST_SCAN;
                end else begin
                    deb_nxt = deb_cnt + DEB_W'(1);
                end
            end
            default: state_nxt = ST_SCAN;
        endcase

        if (clear) begin
            value_nxt = '0;
        end
    end

endmodule

// File: tb/tb_keypad_reader.sv
// Randomized self-checking bench for keypad_reader using a press-level reference model.
module tb_keypad_reader;

    localparam int unsigned SD = 4;
    localparam int unsigned DC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value_out;
    logic        key_held;

    int          total = 0;
    int          bad   = 0;
    int          pulses;
    logic [3:0]  pulse_code;
    bit          held_seen;
    logic [15:0] m_value;
    logic [3:0]  m_code;

    keypad_reader #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .clear     (clear),
        .col_out   (col_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value_out (value_out),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return 4'hF ^ (one << c);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and tallying pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("col_onehot", 32'($countones(~col_out)), 32'd1);
            if (key_valid === 1'b1) begin
                pulses++;
                pulse_code = key_code;
            end
            if (key_held === 1'b1) held_seen = 1'b1;
        end
    endtask

    // Return just after col_out switches to column c.
    task automatic wait_col(input int c);
        logic [3:0] prev;
        prev = col_out;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (col_out == col_pat(c) && prev != col_out) return;
            prev = col_out;
        end
        check("wait_col_timeout", 32'd0, 32'd1);
    endtask

    // Press key (r,c) for lo1 cycles, optional bounce gap then lo2 more, then release.
    task automatic press(input int r, input int c, input int lo1, input int gap,
                         input int lo2, input int clr_at);
        bit         acc;
        bit         clr_hit;
        logic [3:0] code;
        logic [3:0] low;
        int         exp_pulses;
        int         k;
        pulses    = 0;
        held_seen = 1'b0;
        wait_col(c);
        code = 4'(r * 4 + c);
        low  = col_pat(r);
        acc  = (lo1 >= int'(DC) + 1) || (gap > 0 && lo2 >= int'(DC) + 1);
        clr_hit = acc && (clr_at == int'(DC) + 3) && (lo1 >= int'(DC) + 1);
        row_in = low;
        for (int i = 1; i <= lo1; i++) begin
            clear = (i == clr_at);
            step(1);
        end
        clear = 1'b0;
        if (gap > 0) begin
            row_in = 4'hF;
            step(gap);
            row_in = low;
            step(lo2);
        end
        row_in = 4'hF;
        exp_pulses = 0;
        if (acc && clr_hit) begin
            m_value = 16'h0000;
        end else if (acc) begin
            m_value    = {m_value[11:0], code};
            m_code     = code;
            exp_pulses = 1;
        end
        if (acc) begin
            k = 0;
            while (key_held === 1'b1 && k < 60) begin
                step(1);
                k++;
            end
            check("held_fall_cycles", 32'(k), 32'(DC + 3));
            check("col_after_release", 32'(col_out), 32'(col_pat((c + 1) % 4)));
            check("held_seen", 32'(held_seen), 32'd1);
        end else begin
            step(4);
            check("col_unchanged", 32'(col_out), 32'(col_pat(c)));
            check("no_held", 32'(held_seen), 32'd0);
        end
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        if (exp_pulses == 1) check("pulse_code", 32'(pulse_code), 32'(code));
        check("key_code", 32'(key_code), 32'(m_code));
        check("value_out", 32'(value_out), 32'(m_value));
    endtask

    // Press key (r,c), then reset after t cycles with the key still down.
    task automatic press_reset(input int r, input int c, input int t);
        int exp_pulses;
        pulses = 0;
        wait_col(c);
        row_in = col_pat(r);
        step(t);
        exp_pulses = (t >= int'(DC) + 3) ? 1 : 0;
        rst    = 1'b1;
        row_in = 4'hF;
        step(1);
        rst = 1'b0;
        check("rst_col", 32'(col_out), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_value", 32'(value_out), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        m_value = 16'h0000;
        m_code  = 4'h0;
        step(20);
        check("rst_pulses", 32'(pulses), 32'(exp_pulses));
    endtask

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        row_in  = 4'hF;
        m_value = 16'h0000;
        m_code  = 4'h0;
        pulses  = 0;
        held_seen = 1'b0;
        step(3);
        check("reset_col", 32'(col_out), 32'h0000000E);
        check("reset_valid", 32'(key_valid), 32'd0);
        check("reset_code", 32'(key_code), 32'd0);
        check("reset_value", 32'(value_out), 32'd0);
        check("reset_held", 32'(key_held), 32'd0);
        rst = 1'b0;

        // Idle rotation: column index advances every SD cycles.
        for (int k = 1; k <= 32; k++) begin
            step(1);
            check("idle_col", 32'(col_out), 32'(col_pat((k / int'(SD)) % 4)));
            check("idle_valid", 32'(key_valid), 32'd0);
        end

        press(2, 1, 20, 0, 0, 0);
        check("key9_value", 32'(value_out), 32'h00000009);
        press(0, 3, 5, 1, 5, 0);
        press(1, 2, 14, 0, 0, int'(DC) + 3);
        check("clear_at_accept", 32'(value_out), 32'd0);

        for (int key = 1; key <= 5; key++) begin
            press(key / 4, key % 4, 12, 0, 0, 0);
        end
        check("value_2345", 32'(value_out), 32'h00002345);

        press_reset(3, 0, 6);
        press_reset(1, 3, 20);

        for (int n = 0; n < 16; n++) begin
            press(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(14, 3)), int'($urandom_range(1, 0)),
                  int'($urandom_range(14, 3)), 0);
        end

        clear = 1'b1;
        step(1);
        clear = 1'b0;
        m_value = 16'h0000;
        check("idle_clear", 32'(value_out), 32'(m_value));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
